// File: rtl/freelist_ckpt_pkg.sv
// Shared definitions for the checkpointed rename free list.
package freelist_ckpt_pkg;
  localparam int ARCH_REG_SZ  = 32;
  localparam int FL_DEPTH     = 32;
  localparam int FL_N         = 3;
  localparam int FL_CKPT_NUM  = 4;
  localparam int FL_PHYS_BASE = ARCH_REG_SZ;
  localparam int FL_PW        = $clog2(FL_PHYS_BASE + FL_DEPTH);
  localparam int FL_PTRW      = $clog2(FL_DEPTH) + 1;
  localparam int FL_CW        = $clog2(FL_CKPT_NUM);

  typedef logic [FL_PTRW-1:0] FL_PTR_T;

  typedef struct packed {
    logic [FL_PW-1:0] reg_idx;
    logic             valid;
  } FREE_LIST_PACKET;
endpackage

// File: rtl/freelist_ckpt_if.sv
// Rename/retire/branch-stack port bundle of the free list.
interface freelist_ckpt_if
  import freelist_ckpt_pkg::*;
#(
  parameter int DEPTH     = FL_DEPTH,
  parameter int N         = FL_N,
  parameter int CKPT_NUM  = FL_CKPT_NUM,
  parameter int PHYS_BASE = FL_PHYS_BASE
);
  localparam int PW   = $clog2(PHYS_BASE + DEPTH);
  localparam int CW   = $clog2(CKPT_NUM);
  localparam int RW   = $clog2(N + 1);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [RW-1:0]          alloc_req_num;
  logic                   alloc_ok;
  logic [N-1:0][PW-1:0]   alloc_reg;
  logic [N-1:0]           free_valid;
  logic [N-1:0][PW-1:0]   free_reg;
  logic [CNTW-1:0]        num_avail;
  logic                   ckpt_save;
  logic                   ckpt_release;
  logic [CW-1:0]          ckpt_rel_id;
  logic                   ckpt_restore;
  logic [CW-1:0]          ckpt_id;
  logic [CKPT_NUM-1:0]    ckpt_valid;
  logic                   err_overflow;

  modport master (
    output alloc_req_num, free_valid, free_reg, ckpt_save, ckpt_release,
           ckpt_rel_id, ckpt_restore, ckpt_id,
    input  alloc_ok, alloc_reg, num_avail, ckpt_valid, err_overflow
  );

  modport slave (
    input  alloc_req_num, free_valid, free_reg, ckpt_save, ckpt_release,
           ckpt_rel_id, ckpt_restore, ckpt_id,
    output alloc_ok, alloc_reg, num_avail, ckpt_valid, err_overflow
  );
endinterface

// File: rtl/freelist_compact.sv
// N-lane mask compactor: per-lane prefix offset of set bits plus total popcount.
module freelist_compact #(
  parameter int N  = 3,
  parameter int OW = $clog2(N + 1)
)(
  input  logic [N-1:0]         mask,
  output logic [N-1:0][OW-1:0] offset,
  output logic [OW-1:0]        count
);
  logic [OW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = acc;
      acc       = acc + OW'(mask[i]);
    end
    count = acc;
  end
endmodule

// File: rtl/freelist_ckpt.sv
// Circular physical-register free list with head checkpoints for branch recovery.
// Optional FREELIST_DEBUG_EN exposes internal state ports and a grant trace.
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int DEPTH     = FL_DEPTH,
  parameter int N         = FL_N,
  parameter int CKPT_NUM  = FL_CKPT_NUM,
  parameter int PHYS_BASE = FL_PHYS_BASE
)(
  input logic            clock,
  input logic            reset_n,
  freelist_ckpt_if.slave fl
`ifdef FREELIST_DEBUG_EN
  ,
  output logic [DEPTH-1:0][$clog2(PHYS_BASE+DEPTH)-1:0] debug_entries,
  output logic [$clog2(DEPTH):0]                        debug_head,
  output logic [$clog2(DEPTH):0]                        debug_tail,
  output logic [CKPT_NUM-1:0][$clog2(DEPTH):0]          debug_ckpt
`endif
);
  localparam int PW   = $clog2(PHYS_BASE + DEPTH);
  localparam int PTRW = $clog2(DEPTH) + 1;
  localparam int IW   = PTRW - 1;
  localparam int RW   = $clog2(N + 1);

  typedef logic [PTRW-1:0] ptr_t;

  logic [PW-1:0]        entries [DEPTH];
  ptr_t                 head, tail;
  ptr_t                 ckpt_ptr [CKPT_NUM];
  logic [CKPT_NUM-1:0]  ckpt_vld;
  logic                 err_q;

  ptr_t                 occ, head_nxt, occ_nxt, space, free_cnt_p, tail_add, save_ptr;
  logic                 restore_hit, grant, overflow;
  logic [N-1:0][RW-1:0] lane_off;
  logic [RW-1:0]        free_cnt;
  logic [N-1:0]         lane_acc;
  logic [N-1:0][IW-1:0] wr_idx;

  freelist_compact #(.N(N), .OW(RW)) u_compact (
    .mask   (fl.free_valid),
    .offset (lane_off),
    .count  (free_cnt)
  );

  assign occ         = tail - head;
  assign restore_hit = fl.ckpt_restore && ckpt_vld[fl.ckpt_id];
  assign grant       = (occ >= PTRW'(fl.alloc_req_num)) && !restore_hit;
  assign save_ptr    = head + (grant ? PTRW'(fl.alloc_req_num) : '0);
  assign head_nxt    = restore_hit ? ckpt_ptr[fl.ckpt_id] : save_ptr;

  // Room for frees is measured against the head that will exist after this
  // edge, so a same-cycle allocation or restore is accounted for.
  assign occ_nxt    = tail - head_nxt;
  assign space      = (occ_nxt >= PTRW'(DEPTH)) ? '0 : PTRW'(DEPTH) - occ_nxt;
  assign free_cnt_p = PTRW'(free_cnt);
  assign overflow   = free_cnt_p > space;
  assign tail_add   = overflow ? space : free_cnt_p;

  for (genvar i = 0; i < N; i++) begin : g_lane
    ptr_t rd_ptr, wr_ptr;
    assign rd_ptr          = head + PTRW'(i);
    assign fl.alloc_reg[i] = entries[rd_ptr[IW-1:0]];
    assign wr_ptr          = tail + PTRW'(lane_off[i]);
    assign wr_idx[i]       = wr_ptr[IW-1:0];
    assign lane_acc[i]     = fl.free_valid[i] && (PTRW'(lane_off[i]) < space);
  end

  assign fl.alloc_ok     = grant;
  assign fl.num_avail    = occ;
  assign fl.ckpt_valid   = ckpt_vld;
  assign fl.err_overflow = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= PTRW'(DEPTH);
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= PW'(PHYS_BASE + i);
    end else begin
      head <= head_nxt;
      tail <= tail + tail_add;
      if (overflow) err_q <= 1'b1;
      for (int i = 0; i < N; i++)
        if (lane_acc[i]) entries[wr_idx[i]] <= fl.free_reg[i];
    end
  end

  // A taken restore squashes every younger branch, so all slots drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ckpt_vld <= '0;
      for (int i = 0; i < CKPT_NUM; i++) ckpt_ptr[i] <= '0;
    end else if (restore_hit) begin
      ckpt_vld <= '0;
    end else begin
      if (fl.ckpt_release) ckpt_vld[fl.ckpt_rel_id] <= 1'b0;
      if (fl.ckpt_save) begin
        ckpt_vld[fl.ckpt_id] <= 1'b1;
        ckpt_ptr[fl.ckpt_id] <= save_ptr;
      end
    end
  end

`ifdef FREELIST_DEBUG_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_dbg_ent
    assign debug_entries[i] = entries[i];
  end
  for (genvar i = 0; i < CKPT_NUM; i++) begin : g_dbg_ck
    assign debug_ckpt[i] = ckpt_ptr[i];
  end
  assign debug_head = head;
  assign debug_tail = tail;
`ifndef DC
  always @(negedge clock) begin
    if (reset_n && grant)
      for (int i = 0; i < N; i++)
        if (i < int'(fl.alloc_req_num))
          $display("%0t freelist grant lane %0d preg %0d", $time, i, fl.alloc_reg[i]);
  end
`endif
`endif
endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: directed vector table plus randomized model comparison.
module tb_freelist_ckpt;
  import freelist_ckpt_pkg::*;

  localparam int DEPTH = FL_DEPTH;
  localparam int N     = FL_N;
  localparam int CKN   = FL_CKPT_NUM;
  localparam int PB    = FL_PHYS_BASE;
  localparam int PW    = $clog2(PB + DEPTH);
  localparam int CW    = $clog2(CKN);
  localparam int RW    = $clog2(N + 1);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  freelist_ckpt_if fl ();

`ifdef FREELIST_DEBUG_EN
  logic [DEPTH-1:0][PW-1:0]          debug_entries;
  logic [$clog2(DEPTH):0]            debug_head, debug_tail;
  logic [CKN-1:0][$clog2(DEPTH):0]   debug_ckpt;
`endif

  freelist_ckpt dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fl      (fl)
`ifdef FREELIST_DEBUG_EN
    ,
    .debug_entries (debug_entries),
    .debug_head    (debug_head),
    .debug_tail    (debug_tail),
    .debug_ckpt    (debug_ckpt)
`endif
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(string name, logic [31:0] act, int exp);
    nvec++;
    if (act !== 32'(exp)) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus state ----------------
  int       s_req, s_rid, s_id;
  bit [2:0] s_fv;
  int       s_fr [N];
  bit       s_sv, s_rl, s_rs;

  task automatic apply();
    fl.alloc_req_num = RW'(s_req);
    fl.free_valid    = s_fv;
    for (int i = 0; i < N; i++) fl.free_reg[i] = PW'(s_fr[i]);
    fl.ckpt_save     = s_sv;
    fl.ckpt_release  = s_rl;
    fl.ckpt_rel_id   = CW'(s_rid);
    fl.ckpt_restore  = s_rs;
    fl.ckpt_id       = CW'(s_id);
  endtask

  task automatic idle_inputs();
    s_req = 0; s_fv = '0; s_sv = 0; s_rl = 0; s_rs = 0; s_rid = 0; s_id = 0;
    for (int i = 0; i < N; i++) s_fr[i] = 0;
    apply();
  endtask

  // ---------------- reference model ----------------
  // Unbounded integer pointers over a circular array; checkpoints hold head values.
  int           m_head, m_tail;
  int           m_mem [DEPTH];
  int           m_ck  [CKN];
  bit [CKN-1:0] m_ckv;
  bit           m_err;

  function automatic void model_reset();
    m_head = 0;
    m_tail = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = PB + i;
    for (int i = 0; i < CKN; i++) m_ck[i] = 0;
    m_ckv = '0;
    m_err = 0;
  endfunction

  task automatic mstep(string tag);
    int avail, new_head, room;
    bit hit, ok;
    avail = m_tail - m_head;
    hit   = s_rs && m_ckv[s_id];
    ok    = (avail >= s_req) && !hit;
    chk({tag, " alloc_ok"}, 32'(fl.alloc_ok), int'(ok));
    chk({tag, " num_avail"}, 32'(fl.num_avail), avail);
    chk({tag, " ckpt_valid"}, 32'(fl.ckpt_valid), int'(m_ckv));
    chk({tag, " err_overflow"}, 32'(fl.err_overflow), int'(m_err));
    if (ok)
      for (int i = 0; i < s_req; i++)
        chk($sformatf("%s alloc_reg[%0d]", tag, i), 32'(fl.alloc_reg[i]),
            m_mem[(m_head + i) % DEPTH]);
    new_head = hit ? m_ck[s_id] : (ok ? m_head + s_req : m_head);
    room = DEPTH - (m_tail - new_head);
    if (room < 0) room = 0;
    for (int i = 0; i < N; i++)
      if (s_fv[i]) begin
        if (room > 0) begin
          m_mem[m_tail % DEPTH] = s_fr[i];
          m_tail++;
          room--;
        end else m_err = 1;
      end
    if (hit) m_ckv = '0;
    else begin
      if (s_rl) m_ckv[s_rid] = 1'b0;
      if (s_sv) begin
        m_ck[s_id]  = m_head + (ok ? s_req : 0);
        m_ckv[s_id] = 1'b1;
      end
    end
    m_head = new_head;
  endtask

  task automatic mcycle(string tag);
    @(negedge clock);
    apply();
    #1;
    mstep(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset num_avail", 32'(fl.num_avail), DEPTH);
    chk("reset alloc_ok", 32'(fl.alloc_ok), 1);
    chk("reset ckpt_valid", 32'(fl.ckpt_valid), 0);
    chk("reset err_overflow", 32'(fl.err_overflow), 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("reset alloc_reg[%0d]", i), 32'(fl.alloc_reg[i]), PB + i);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       pre_rst;
    int       req;
    bit [2:0] fv;
    int       f0, f1, f2;
    bit       sv, rl;
    int       rid;
    bit       rs;
    int       id;
    bit       e_ok;
    int       e_avail, e_n, e_r0, e_r1, e_r2, e_ckv;
    bit       e_err;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(bit pr, int req, bit [2:0] fv, int f0, int f1, int f2,
                              bit sv, bit rl, int rid, bit rs, int id,
                              bit ok, int av, int n, int r0, int r1, int r2,
                              int ckv, bit err);
    vec_t v;
    v.pre_rst = pr; v.req = req; v.fv = fv; v.f0 = f0; v.f1 = f1; v.f2 = f2;
    v.sv = sv; v.rl = rl; v.rid = rid; v.rs = rs; v.id = id;
    v.e_ok = ok; v.e_avail = av; v.e_n = n; v.e_r0 = r0; v.e_r1 = r1; v.e_r2 = r2;
    v.e_ckv = ckv; v.e_err = err;
    tbl.push_back(v);
  endfunction

  initial begin
    int exp_r [N];

    // Allocation from reset down to empty, then compacted free.
    add(1, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 3, 32, 33, 34, 0, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 29, 3, 35, 36, 37, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 26 - 3*k, 3, 38 + 3*k, 39 + 3*k, 40 + 3*k, 0, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0,  0,  0, 0, 0);
    add(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 2, 62, 63,  0, 0, 0);
    add(0, 1, 3'b101, 40, 7, 41, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0);
    add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 3, 40, 41, 34, 0, 0);
    add(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 2, 40, 41,  0, 0, 0);
    add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0,  0,  0,  0, 0, 0);
    // Checkpoint save / restore / release interactions.
    add(1, 2, 3'b000, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32, 2, 32, 33,  0, 0, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 3, 34, 35, 36, 2, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 27, 3, 37, 38, 39, 2, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 24, 0,  0,  0,  0, 2, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 3, 34, 35, 36, 0, 0);
    add(0, 1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 2, 1, 27, 1, 37,  0,  0, 0, 0);
    add(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 26, 2, 38, 39,  0, 4, 0);
    add(0, 1, 3'b001, 50, 0, 0, 1, 0, 0, 1, 2, 0, 24, 0,  0,  0,  0, 4, 0);
    add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 27, 0,  0,  0,  0, 0, 0);
    add(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 1, 27, 2, 38, 39,  0, 0, 0);
    add(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 25, 2, 40, 41,  0, 0, 0);
    add(0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 3, 1, 23, 0,  0,  0,  0, 0, 0);
    add(0, 1, 3'b000, 0, 0, 0, 1, 1, 3, 0, 3, 1, 23, 1, 42,  0,  0, 8, 0);
    add(0, 0, 3'b000, 0, 0, 0, 0, 1, 3, 0, 0, 1, 22, 0,  0,  0,  0, 8, 0);
    add(0, 2, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 22, 2, 43, 44,  0, 0, 0);
    add(0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 3, 45, 46, 47, 1, 0);
    add(0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 1, 0, 0, 17, 0,  0,  0,  0, 1, 0);
    add(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 45,  0,  0, 0, 0);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[v]) begin
      if (tbl[v].pre_rst) do_reset();
      @(negedge clock);
      s_req = tbl[v].req; s_fv = tbl[v].fv;
      s_fr[0] = tbl[v].f0; s_fr[1] = tbl[v].f1; s_fr[2] = tbl[v].f2;
      s_sv = tbl[v].sv; s_rl = tbl[v].rl; s_rid = tbl[v].rid;
      s_rs = tbl[v].rs; s_id = tbl[v].id;
      apply();
      #1;
      chk($sformatf("vec%0d alloc_ok", v), 32'(fl.alloc_ok), int'(tbl[v].e_ok));
      chk($sformatf("vec%0d num_avail", v), 32'(fl.num_avail), tbl[v].e_avail);
      chk($sformatf("vec%0d ckpt_valid", v), 32'(fl.ckpt_valid), tbl[v].e_ckv);
      chk($sformatf("vec%0d err_overflow", v), 32'(fl.err_overflow), int'(tbl[v].e_err));
      exp_r[0] = tbl[v].e_r0; exp_r[1] = tbl[v].e_r1; exp_r[2] = tbl[v].e_r2;
      for (int i = 0; i < tbl[v].e_n; i++)
        chk($sformatf("vec%0d alloc_reg[%0d]", v, i), 32'(fl.alloc_reg[i]), exp_r[i]);
    end

    // Steady allocate/free traffic wraps the pointers, then a free into a full list.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      s_req = 3; s_fv = 3'b111; s_sv = 0; s_rl = 0; s_rs = 0;
      for (int i = 0; i < N; i++) s_fr[i] = (k * 3 + i) % (PB + DEPTH);
      mcycle($sformatf("wrap%0d", k));
    end
    s_req = 0; s_fv = 3'b111;
    mcycle("full_free");
    s_fv = 3'b000;
    mcycle("post_full");
    chk("overflow err_overflow", 32'(fl.err_overflow), 1);
    chk("overflow num_avail", 32'(fl.num_avail), DEPTH);

    // Asynchronous reset in the middle of activity.
    s_req = 1; s_sv = 1; s_id = 1;
    mcycle("pre_rst_save");
    s_req = 2; s_sv = 0;
    mcycle("pre_rst_alloc");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst num_avail", 32'(fl.num_avail), DEPTH);
    chk("midrst ckpt_valid", 32'(fl.ckpt_valid), 0);
    chk("midrst err_overflow", 32'(fl.err_overflow), 0);
    chk("midrst alloc_reg[0]", 32'(fl.alloc_reg[0]), PB);
    idle_inputs();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      s_req = $urandom_range(0, N);
      s_fv  = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) s_fr[i] = $urandom_range(0, PB + DEPTH - 1);
      s_sv  = ($urandom_range(0, 3) == 0);
      s_rl  = ($urandom_range(0, 3) == 0);
      s_rid = $urandom_range(0, CKN - 1);
      s_id  = $urandom_range(0, CKN - 1);
      s_rs  = ($urandom_range(0, 7) == 0);
      // A restore is only meaningful while the checkpointed entries are intact.
      if (s_rs && m_ckv[s_id] && (m_tail - m_ck[s_id] > DEPTH)) s_rs = 0;
      mcycle($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
